// File: rtl/loader_pkg.sv
// Shared types and constants for the ioctl download-to-memory loader.
// Optional LOADER_CHECKSUM_EN build option is consumed by ioctl_mem_loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } loader_state_t;

  localparam logic [7:0] CMOS_INDEX_DEFAULT = 8'hFF;

  // Select/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ioctl_mem_loader_fifo.sv
// Small synchronous FIFO with first-word fall-through read; push and pop
// in the same cycle are both honoured even when full.
module loader_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ioctl_mem_loader.sv
// Buffers data_io download bytes, relocates them per image index and writes
// one byte per mem_sync slot; sequences the core reset. Option: LOADER_CHECKSUM_EN.
module ioctl_mem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W      = 25,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         NUM_REGIONS = 4,
  parameter int         RESET_HOLD  = 4095,
  parameter logic [7:0] CMOS_INDEX  = CMOS_INDEX_DEFAULT
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          ioctl_download,
  input  logic [7:0]                    ioctl_index,
  input  logic                          ioctl_wr,
  input  logic [ADDR_W-1:0]             ioctl_addr,
  input  logic [7:0]                    ioctl_dout,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
  input  logic                          mem_sync,
  input  logic                          cfg_change,
  output logic                          loader_active,
  output logic                          loader_we,
  output logic [ADDR_W-1:0]             loader_addr,
  output logic [7:0]                    loader_data,
  output logic                          core_reset_req,
  output logic                          overflow,
  output logic                          unmapped,
  output logic [15:0]                   checksum
);

  localparam int              SEL_W     = clog2_min1(NUM_REGIONS);
  localparam int              CNT_W     = clog2_min1(RESET_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD);
  localparam logic [8:0]      NUM_REG_L = 9'(NUM_REGIONS);

  loader_state_t     r_state;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic              r_loader_active;
  logic              r_core_reset_req;
  logic              r_loader_we;
  logic [ADDR_W-1:0] r_loader_addr;
  logic [7:0]        r_loader_data;
  logic              r_overflow;
  logic              r_unmapped;
  logic              r_dl_prev;

  logic              w_dl_rise;
  logic              w_in_range;
  logic              w_accept;
  logic              w_unmapped_hit;
  logic              w_overflow_hit;
  logic [SEL_W-1:0]  w_sel;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W+7:0] w_entry;
  logic [ADDR_W+7:0] w_fifo_rd;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_dl_rise      = ioctl_download && !r_dl_prev;
  assign w_in_range     = ({1'b0, ioctl_index} < NUM_REG_L);
  assign w_accept       = ioctl_wr && ioctl_download && w_in_range;
  assign w_unmapped_hit = ioctl_wr && ioctl_download && !w_in_range && (ioctl_index != CMOS_INDEX);
  assign w_sel          = ioctl_index[SEL_W-1:0];
  assign w_base         = region_base[32'(w_sel)*ADDR_W +: ADDR_W];
  assign w_entry        = {w_base + ioctl_addr, ioctl_dout};
  assign w_pop          = mem_sync && !w_empty;
  // A full FIFO still takes a byte when the same cycle frees a slot.
  assign w_push         = w_accept && (!w_full || w_pop);
  assign w_overflow_hit = w_accept && w_full && !w_pop;

  loader_fifo #(
    .WIDTH(ADDR_W + 8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (clk_sys),
    .i_srst   (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wr_data(w_entry),
    .o_rd_data(w_fifo_rd),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_loader_we   <= 1'b0;
      r_loader_addr <= '0;
      r_loader_data <= '0;
    end else if (mem_sync) begin
      if (!w_empty) begin
        r_loader_we   <= 1'b1;
        r_loader_addr <= w_fifo_rd[ADDR_W+7:8];
        r_loader_data <= w_fifo_rd[7:0];
      end else begin
        r_loader_we   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dl_prev  <= 1'b0;
      r_overflow <= 1'b0;
      r_unmapped <= 1'b0;
    end else begin
      r_dl_prev  <= ioctl_download;
      r_overflow <= (r_overflow && !w_dl_rise) || w_overflow_hit;
      r_unmapped <= (r_unmapped && !w_dl_rise) || w_unmapped_hit;
    end
  end

  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state          <= IDLE;
      r_hold_cnt       <= HOLD_LOAD;
      r_loader_active  <= 1'b0;
      r_core_reset_req <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (ioctl_download) begin
            r_state          <= LOAD;
            r_loader_active  <= 1'b1;
            r_core_reset_req <= 1'b1;
          end else if (cfg_change) begin
            r_state          <= HOLD;
            r_hold_cnt       <= HOLD_LOAD;
            r_core_reset_req <= 1'b1;
          end else begin
            r_loader_active  <= 1'b0;
            r_core_reset_req <= 1'b0;
          end
        end
        LOAD: begin
          if (!ioctl_download) r_state <= DRAIN;
        end
        DRAIN: begin
          if (ioctl_download) begin
            r_state <= LOAD;
          end else if (mem_sync && w_empty && !r_loader_we) begin
            r_state         <= HOLD;
            r_hold_cnt      <= HOLD_LOAD;
            r_loader_active <= 1'b0;
          end
        end
        HOLD: begin
          if (ioctl_download) begin
            r_state         <= LOAD;
            r_loader_active <= 1'b1;
          end else if (cfg_change) begin
            r_hold_cnt <= HOLD_LOAD;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
            if (r_hold_cnt <= CNT_W'(1)) begin
              r_state          <= IDLE;
              r_hold_cnt       <= '0;
              r_core_reset_req <= 1'b0;
            end
          end
        end
        default: begin
          r_state          <= IDLE;
          r_loader_active  <= 1'b0;
          r_core_reset_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_checksum <= '0;
    end else begin
      r_checksum <= (w_dl_rise ? 16'h0000 : r_checksum) + (w_push ? {8'h00, ioctl_dout} : 16'h0000);
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 16'h0000;
`endif

  assign loader_active  = r_loader_active;
  assign loader_we      = r_loader_we;
  assign loader_addr    = r_loader_addr;
  assign loader_data    = r_loader_data;
  assign core_reset_req = r_core_reset_req;
  assign overflow       = r_overflow;
  assign unmapped       = r_unmapped;

endmodule

// File: tb/tb_ioctl_mem_loader.sv
// Directed self-checking bench for ioctl_mem_loader with a short reset hold.
`timescale 1ns/1ps
module tb_ioctl_mem_loader;

  localparam int ADDR_W = 25;
  localparam int NREG   = 4;
  localparam int HOLD_N = 10;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_download = 1'b0;
  logic [7:0]        ioctl_index = 8'h00;
  logic              ioctl_wr = 1'b0;
  logic [ADDR_W-1:0] ioctl_addr = '0;
  logic [7:0]        ioctl_dout = 8'h00;
  logic [NREG*ADDR_W-1:0] region_base;
  logic              mem_sync = 1'b0;
  logic              cfg_change = 1'b0;
  logic              loader_active;
  logic              loader_we;
  logic [ADDR_W-1:0] loader_addr;
  logic [7:0]        loader_data;
  logic              core_reset_req;
  logic              overflow;
  logic              unmapped;
  logic [15:0]       checksum;

  int n_tests = 0;
  int n_fail  = 0;

  ioctl_mem_loader #(
    .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .NUM_REGIONS(NREG),
    .RESET_HOLD(HOLD_N), .CMOS_INDEX(8'hFF)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .region_base(region_base), .mem_sync(mem_sync),
    .cfg_change(cfg_change), .loader_active(loader_active), .loader_we(loader_we),
    .loader_addr(loader_addr), .loader_data(loader_data),
    .core_reset_req(core_reset_req), .overflow(overflow), .unmapped(unmapped),
    .checksum(checksum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] idx, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  task automatic slot();
    mem_sync = 1'b1;
    tick();
    mem_sync = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    slot();
    check_eq({tag, ".we"}, 32'(loader_we), 32'd1);
    check_eq({tag, ".addr"}, 32'(loader_addr), 32'(a));
    check_eq({tag, ".data"}, 32'(loader_data), 32'(d));
  endtask

  task automatic expect_sum(input string tag, input logic [15:0] s);
`ifdef LOADER_CHECKSUM_EN
    check_eq(tag, 32'(checksum), 32'(s));
`else
    check_eq(tag, 32'(checksum), 32'(s & 16'h0000));
`endif
  endtask

  initial begin
    region_base = {25'h0, 25'h0, 25'h1FFFFFF, 25'h80000};

    // Reset values
    tick(2);
    check_eq("rst.core_reset_req", 32'(core_reset_req), 32'd1);
    check_eq("rst.loader_we", 32'(loader_we), 32'd0);
    check_eq("rst.loader_active", 32'(loader_active), 32'd0);
    check_eq("rst.overflow", 32'(overflow), 32'd0);
    check_eq("rst.unmapped", 32'(unmapped), 32'd0);
    check_eq("rst.checksum", 32'(checksum), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle.core_reset_req", 32'(core_reset_req), 32'd0);

    // Basic relocated writes, one per slot
    ioctl_download = 1'b1;
    tick();
    check_eq("load.active", 32'(loader_active), 32'd1);
    check_eq("load.core_reset_req", 32'(core_reset_req), 32'd1);
    write_byte(8'h00, 25'd0, 8'hA5);
    expect_write("w0", 25'h80000, 8'hA5);
    tick(7);
    check_eq("w0.we_held", 32'(loader_we), 32'd1);
    write_byte(8'h00, 25'd1, 8'h5A);
    expect_write("w1", 25'h80001, 8'h5A);
    slot();
    check_eq("w1.we_off", 32'(loader_we), 32'd0);
    check_eq("w1.addr_held", 32'(loader_addr), 32'h80001);

    // Three back-to-back bytes between slots
    write_byte(8'h00, 25'd10, 8'h11);
    write_byte(8'h00, 25'd11, 8'h22);
    write_byte(8'h00, 25'd12, 8'h33);
    expect_write("b0", 25'h8000A, 8'h11);
    expect_write("b1", 25'h8000B, 8'h22);
    expect_write("b2", 25'h8000C, 8'h33);
    check_eq("b.overflow", 32'(overflow), 32'd0);
    slot();

    // Six pushes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) begin
      write_byte(8'h00, 25'(20 + i), 8'(8'h40 + i));
      if (i == 3) check_eq("ov.after4", 32'(overflow), 32'd0);
    end
    check_eq("ov.after6", 32'(overflow), 32'd1);
    expect_sum("sum.accepted", 16'h026B);
    expect_write("ov0", 25'h80014, 8'h40);
    expect_write("ov1", 25'h80015, 8'h41);
    expect_write("ov2", 25'h80016, 8'h42);
    expect_write("ov3", 25'h80017, 8'h43);
    slot();
    check_eq("ov.drained_we", 32'(loader_we), 32'd0);
    ioctl_download = 1'b0;
    tick();
    check_eq("drain.active", 32'(loader_active), 32'd1);
    ioctl_download = 1'b1;
    tick();
    check_eq("rise.overflow_clr", 32'(overflow), 32'd0);
    expect_sum("rise.sum_clr", 16'h0000);

    // CMOS and unmapped indices
    write_byte(8'hFF, 25'd0, 8'h77);
    check_eq("cmos.unmapped", 32'(unmapped), 32'd0);
    write_byte(8'h05, 25'd0, 8'h66);
    check_eq("idx5.unmapped", 32'(unmapped), 32'd1);
    slot();
    check_eq("rej.we", 32'(loader_we), 32'd0);
    check_eq("rej.addr_held", 32'(loader_addr), 32'h80017);

    // Address wrap
    write_byte(8'h01, 25'd2, 8'h99);
    expect_write("wrap", 25'h0000001, 8'h99);
    slot();

    // Download ends with two bytes buffered
    write_byte(8'h00, 25'd30, 8'hC1);
    write_byte(8'h00, 25'd31, 8'hC2);
    ioctl_download = 1'b0;
    tick();
    check_eq("end.active", 32'(loader_active), 32'd1);
    expect_write("d0", 25'h8001E, 8'hC1);
    check_eq("d0.active", 32'(loader_active), 32'd1);
    expect_write("d1", 25'h8001F, 8'hC2);
    check_eq("d1.active", 32'(loader_active), 32'd1);
    slot();
    check_eq("d.last_slot_active", 32'(loader_active), 32'd1);
    slot();
    check_eq("hold.active", 32'(loader_active), 32'd0);
    check_eq("hold.req", 32'(core_reset_req), 32'd1);
    tick(HOLD_N - 1);
    check_eq("hold.req_before_end", 32'(core_reset_req), 32'd1);
    tick();
    check_eq("hold.req_released", 32'(core_reset_req), 32'd0);

    // cfg_change from IDLE, retriggered during HOLD
    cfg_change = 1'b1;
    tick();
    cfg_change = 1'b0;
    check_eq("cfg.req", 32'(core_reset_req), 32'd1);
    tick(5);
    cfg_change = 1'b1;
    tick();
    cfg_change = 1'b0;
    tick(HOLD_N - 1);
    check_eq("cfg.req_restarted", 32'(core_reset_req), 32'd1);
    tick();
    check_eq("cfg.req_released", 32'(core_reset_req), 32'd0);

    // Reset in mid-LOAD discards buffered bytes
    ioctl_download = 1'b1;
    tick();
    write_byte(8'h00, 25'd40, 8'hE1);
    write_byte(8'h00, 25'd41, 8'hE2);
    expect_write("mid0", 25'h80028, 8'hE1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    check_eq("midrst.we", 32'(loader_we), 32'd0);
    check_eq("midrst.req", 32'(core_reset_req), 32'd1);
    check_eq("midrst.active", 32'(loader_active), 32'd0);
    reset = 1'b0;
    tick();
    slot();
    check_eq("midrst.fifo_empty", 32'(loader_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ioctl_mem_loader.md
Name: ioctl_mem_loader

Overview:
- Parametrised successor to the single-flag download-to-SDRAM write path.
- Accepts bytes streamed by data_io (ioctl_*) and buffers them in a small FIFO, so back-to-back ioctl writes are never lost.
- Relocates each byte through a per-index region base table and issues one memory write per mem_sync slot to the SDRAM port mux.
- Sequences the core reset request: held during a download, then for a programmable hold period after the download or after any config change.

Parameters:
- ADDR_W, 25, width of ioctl and memory addresses.
- FIFO_DEPTH, 4, entries in the write buffer; power of two, at least 2.
- NUM_REGIONS, 4, number of ioctl_index values with a base address; power of two.
- RESET_HOLD, 4095, clk_sys cycles the reset request stays high after the load completes or a config change; must be at least 1.
- CMOS_INDEX, 8'hFF, ioctl_index reserved for CMOS; never written to memory.

Ports:
- clk_sys  in  1  system clock (48 MHz).
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download in progress, from data_io.
- ioctl_index  in  8  image index of the current download.
- ioctl_wr  in  1  one-cycle strobe; byte valid.
- ioctl_addr  in  ADDR_W  byte offset within the image.
- ioctl_dout  in  8  download byte.
- region_base  in  NUM_REGIONS*ADDR_W  flat base table; region i is bits [i*ADDR_W +: ADDR_W].
- mem_sync  in  1  one-cycle memory slot strobe from the core.
- cfg_change  in  1  pulse (model or ROM-map change); retriggers the reset hold.
- loader_active  out  1  high while the loader owns the memory port.
- loader_we  out  1  write request, valid for one full slot.
- loader_addr  out  ADDR_W  write address.
- loader_data  out  8  write data.
- core_reset_req  out  1  reset request to the core.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- unmapped  out  1  sticky: a byte arrived with index >= NUM_REGIONS (excluding CMOS_INDEX).
- checksum  out  16  running byte sum (see Optional Feature).

Behaviour:
- Reset values: all outputs 0 except core_reset_req, which is 1. On reset the FIFO empties, the state goes to IDLE and the hold counter loads RESET_HOLD. A reset in mid-download discards buffered bytes.
- Accept rule: a byte is accepted when ioctl_wr && ioctl_download && ioctl_index < NUM_REGIONS.
  - Accepted entry = {region_base[ioctl_index] + ioctl_addr, ioctl_dout}.
  - The addition is ADDR_W wide and wraps modulo 2^ADDR_W.
  - Entry is written to the FIFO on the same clock edge.
- Reject rules:
  - CMOS_INDEX bytes are ignored silently.
  - Other indices >= NUM_REGIONS are dropped and set unmapped.
  - A push into a full FIFO with no simultaneous pop is dropped and sets overflow.
  - A push and a pop in the same cycle while full are both accepted.
  - The sticky flags clear on reset and on the rising edge of ioctl_download.
- Slot rule, on each mem_sync cycle:
  - If the FIFO is non-empty: pop, load loader_addr and loader_data, set loader_we=1.
  - If empty: set loader_we=0 and hold loader_addr and loader_data.
  - loader_we therefore changes only on mem_sync edges.
  - Latency: an accepted byte reaches loader_we at the first mem_sync edge after it is written (at least 1 cycle), assuming the FIFO was otherwise empty.
- State machine:
  - IDLE: loader_active=0. Goes to LOAD on ioctl_download=1.
  - LOAD: loader_active=1, core_reset_req=1. Goes to DRAIN when ioctl_download=0.
  - DRAIN: loader_active=1. Goes back to LOAD if ioctl_download rises again. Goes to HOLD at the first mem_sync where the FIFO is empty and loader_we is 0, so the final write slot completes before the port is released.
  - HOLD: loader_active=0, core_reset_req=1. The counter decrements each cycle; at 0 go to IDLE. Goes to LOAD if ioctl_download rises.
- cfg_change: in IDLE or HOLD, cfg_change reloads the counter to RESET_HOLD and enters HOLD. In LOAD or DRAIN it is ignored, because reset is already asserted.
- core_reset_req = (state != IDLE).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: checksum is a 16-bit wrapping sum of accepted bytes. It clears on reset and on the ioctl_download rising edge, and updates on the same edge the byte is pushed (dropped bytes are not added).
- Undefined: checksum is tied to 16'h0000 and no adder is synthesised.

Decomposition:
- Package loader_pkg holds:
  - the loader_state_t enum {IDLE, LOAD, DRAIN, HOLD};
  - the CMOS_INDEX_DEFAULT constant;
  - a clog2-based helper for the region-select width.
- Sub-module loader_fifo: synchronous FIFO with push, pop, full, empty and a width parameter of ADDR_W+8.

Test Plan:
- Region 0 base 25'h80000, index 0, bytes 8'hA5 at addr 0 and 8'h5A at addr 1, mem_sync every 8 cycles -> writes at 25'h80000 and 25'h80001 in order; loader_we high for exactly one slot each.
- Three ioctl_wr on consecutive cycles between two mem_syncs -> all three written over the next three slots; overflow stays 0. The previous single-flag design lost two of these.
- FIFO_DEPTH=4, six back-to-back pushes with no mem_sync -> four entries kept, overflow=1. A new ioctl_download rise clears overflow.
- Index 8'hFF and index 8'h05 bytes -> no writes. unmapped=1 only for 8'h05.
- Base 25'h1FFFFFF, addr 2 -> loader_addr=25'h0000001 (wrap).
- Download ends with two bytes buffered -> loader_active stays 1 until both slots finish. core_reset_req then stays high RESET_HOLD cycles. A cfg_change during HOLD restarts the count. A reset mid-LOAD empties the FIFO with loader_we=0.
